// File: rtl/axi_lite_pmu_counters.sv
// AXI-Lite PMU counter bank: per-event counters with enable, sticky overflow and
// masked level interrupt, accessed through a single-outstanding AXI-Lite slave.
module axi_lite_pmu_counters #(
    parameter int unsigned NumCounters  = 8,
    parameter int unsigned CntWidth     = 32,
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AxiAddrWidth-1:0]   slv_aw_addr_i,
    input  logic                      slv_aw_valid_i,
    output logic                      slv_aw_ready_o,
    input  logic [AxiDataWidth-1:0]   slv_w_data_i,
    input  logic [AxiDataWidth/8-1:0] slv_w_strb_i,
    input  logic                      slv_w_valid_i,
    output logic                      slv_w_ready_o,
    output logic [1:0]                slv_b_resp_o,
    output logic                      slv_b_valid_o,
    input  logic                      slv_b_ready_i,
    input  logic [AxiAddrWidth-1:0]   slv_ar_addr_i,
    input  logic                      slv_ar_valid_i,
    output logic                      slv_ar_ready_o,
    output logic [AxiDataWidth-1:0]   slv_r_data_o,
    output logic [1:0]                slv_r_resp_o,
    output logic                      slv_r_valid_o,
    input  logic                      slv_r_ready_i,
    input  logic [AxiAddrWidth-1:0]   base_addr_i,
    input  logic [NumCounters-1:0]    event_i,
    output logic                      irq_o
);

    localparam int unsigned CntBase    = 64;  // word index of COUNTER[0] (byte offset 0x100)
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    logic                    r_enable;
    logic [NumCounters-1:0]  r_ovf;
    logic [NumCounters-1:0]  r_irq_en;
    logic [NumCounters-1:0]  r_cnt_en;
    logic [CntWidth-1:0]     r_cnt [NumCounters];
    logic                    r_irq;
    logic                    r_b_valid;
    logic [1:0]              r_b_resp;
    logic                    r_r_valid;
    logic [AxiDataWidth-1:0] r_r_data;
    logic [1:0]              r_r_resp;

    logic                    w_enable_d;
    logic [NumCounters-1:0]  w_ovf_d;
    logic [NumCounters-1:0]  w_irq_en_d;
    logic [NumCounters-1:0]  w_cnt_en_d;
    logic [CntWidth-1:0]     w_cnt_d [NumCounters];

    logic [AxiAddrWidth-1:0] w_aw_word;
    logic [AxiAddrWidth-1:0] w_ar_word;
    logic                    w_wr_accept;
    logic                    w_rd_accept;
    logic [AxiDataWidth-1:0] w_wmask;
    logic                    w_wr_ctrl;
    logic                    w_wr_ovf;
    logic                    w_wr_irq_en;
    logic                    w_wr_cnt_en;
    logic [NumCounters-1:0]  w_wr_cnt;
    logic                    w_wr_hit;
    logic                    w_clear_all;
    logic [NumCounters-1:0]  w_inc;
    logic [AxiDataWidth-1:0] w_rdata;
    logic                    w_rd_hit;

    function automatic logic [AxiDataWidth-1:0] merge_strb(
        input logic [AxiDataWidth-1:0] old_val,
        input logic [AxiDataWidth-1:0] new_val,
        input logic [AxiDataWidth-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // Offsets wrap modulo 2^AxiAddrWidth, so addresses below the base decode as errors.
    assign w_aw_word = (slv_aw_addr_i - base_addr_i) >> 2;
    assign w_ar_word = (slv_ar_addr_i - base_addr_i) >> 2;

    assign w_wr_accept    = slv_aw_valid_i & slv_w_valid_i & ~r_b_valid & ~rst_i;
    assign w_rd_accept    = slv_ar_valid_i & ~r_r_valid & ~rst_i;
    assign slv_aw_ready_o = w_wr_accept;
    assign slv_w_ready_o  = w_wr_accept;
    assign slv_ar_ready_o = ~r_r_valid & ~rst_i;

    assign w_inc = {NumCounters{r_enable}} & r_cnt_en & event_i;

    always_comb begin
        w_wmask = '0;
        for (int b = 0; b < AxiDataWidth / 8; b++) begin
            w_wmask[8*b +: 8] = {8{slv_w_strb_i[b]}};
        end
    end

    always_comb begin
        w_wr_ctrl   = w_wr_accept && (w_aw_word == AxiAddrWidth'(0));
        w_wr_ovf    = w_wr_accept && (w_aw_word == AxiAddrWidth'(1));
        w_wr_irq_en = w_wr_accept && (w_aw_word == AxiAddrWidth'(2));
        w_wr_cnt_en = w_wr_accept && (w_aw_word == AxiAddrWidth'(3));
        w_wr_cnt    = '0;
        for (int i = 0; i < NumCounters; i++) begin
            w_wr_cnt[i] = w_wr_accept && (w_aw_word == AxiAddrWidth'(CntBase + i));
        end
        w_wr_hit = w_wr_ctrl | w_wr_ovf | w_wr_irq_en | w_wr_cnt_en | (|w_wr_cnt);
    end

    always_comb begin
        w_rdata  = '0;
        w_rd_hit = 1'b1;
        if (w_ar_word == AxiAddrWidth'(0)) begin
            w_rdata = AxiDataWidth'(r_enable);
        end else if (w_ar_word == AxiAddrWidth'(1)) begin
            w_rdata = AxiDataWidth'(r_ovf);
        end else if (w_ar_word == AxiAddrWidth'(2)) begin
            w_rdata = AxiDataWidth'(r_irq_en);
        end else if (w_ar_word == AxiAddrWidth'(3)) begin
            w_rdata = AxiDataWidth'(r_cnt_en);
        end else begin
            w_rd_hit = 1'b0;
            for (int i = 0; i < NumCounters; i++) begin
                if (w_ar_word == AxiAddrWidth'(CntBase + i)) begin
                    w_rd_hit = 1'b1;
                    w_rdata  = AxiDataWidth'(r_cnt[i]);
                end
            end
        end
    end

    always_comb begin
        w_clear_all = w_wr_ctrl & slv_w_strb_i[0] & slv_w_data_i[1];
        w_enable_d  = (w_wr_ctrl & slv_w_strb_i[0]) ? slv_w_data_i[0] : r_enable;
        w_irq_en_d  = w_wr_irq_en ?
            NumCounters'(merge_strb(AxiDataWidth'(r_irq_en), slv_w_data_i, w_wmask)) : r_irq_en;
        w_cnt_en_d  = w_wr_cnt_en ?
            NumCounters'(merge_strb(AxiDataWidth'(r_cnt_en), slv_w_data_i, w_wmask)) : r_cnt_en;
        w_ovf_d     = r_ovf;
        if (w_wr_ovf) begin
            w_ovf_d = r_ovf & ~NumCounters'(slv_w_data_i & w_wmask);
        end
        // Hardware overflow set is applied after W1C so it wins on the same bit.
        for (int i = 0; i < NumCounters; i++) begin
            w_cnt_d[i] = r_cnt[i];
            if (w_clear_all) begin
                w_cnt_d[i] = '0;
            end else if (w_wr_cnt[i]) begin
                w_cnt_d[i] = CntWidth'(merge_strb(AxiDataWidth'(r_cnt[i]), slv_w_data_i,
                                                  w_wmask));
            end else if (w_inc[i]) begin
                w_cnt_d[i] = r_cnt[i] + CntWidth'(1);
                if (&r_cnt[i]) begin
                    w_ovf_d[i] = 1'b1;
                end
            end
        end
        if (w_clear_all) begin
            w_ovf_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_enable <= 1'b0;
            r_ovf    <= '0;
            r_irq_en <= '0;
            r_cnt_en <= '0;
            r_irq    <= 1'b0;
            for (int i = 0; i < NumCounters; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_enable <= w_enable_d;
            r_ovf    <= w_ovf_d;
            r_irq_en <= w_irq_en_d;
            r_cnt_en <= w_cnt_en_d;
            r_irq    <= |(r_ovf & r_irq_en);
            for (int i = 0; i < NumCounters; i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_b_valid <= 1'b0;
            r_b_resp  <= RespOkay;
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
            r_r_resp  <= RespOkay;
        end else begin
            if (w_wr_accept) begin
                r_b_valid <= 1'b1;
                r_b_resp  <= w_wr_hit ? RespOkay : RespSlvErr;
            end else if (slv_b_ready_i) begin
                r_b_valid <= 1'b0;
            end
            // Sampled before this edge's register update: same-cycle writes are not visible.
            if (w_rd_accept) begin
                r_r_valid <= 1'b1;
                r_r_data  <= w_rdata;
                r_r_resp  <= w_rd_hit ? RespOkay : RespSlvErr;
            end else if (slv_r_ready_i) begin
                r_r_valid <= 1'b0;
            end
        end
    end

    assign slv_b_valid_o = r_b_valid;
    assign slv_b_resp_o  = r_b_resp;
    assign slv_r_valid_o = r_r_valid;
    assign slv_r_data_o  = r_r_data;
    assign slv_r_resp_o  = r_r_resp;
    assign irq_o         = r_irq;

endmodule

// File: tb/tb_axi_lite_pmu_counters.sv
// Bench for axi_lite_pmu_counters: directed AXI-Lite traffic, a register-map model
// checked every cycle, and hand-computed read-back values.
module tb_axi_lite_pmu_counters;

    localparam int          NC     = 8;
    localparam logic [31:0] Base   = 32'h1040_4000;
    localparam logic [1:0]  Okay   = 2'b00;
    localparam logic [1:0]  SlvErr = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   aw_addr;
    logic          aw_valid;
    logic          aw_ready;
    logic [31:0]   w_data;
    logic [3:0]    w_strb;
    logic          w_valid;
    logic          w_ready;
    logic [1:0]    b_resp;
    logic          b_valid;
    logic          b_ready;
    logic [31:0]   ar_addr;
    logic          ar_valid;
    logic          ar_ready;
    logic [31:0]   r_data;
    logic [1:0]    r_resp;
    logic          r_valid;
    logic          r_ready;
    logic [NC-1:0] ev;
    logic          irq;

    always #5 clk = ~clk;

    axi_lite_pmu_counters #(
        .NumCounters  (NC),
        .CntWidth     (32),
        .AxiAddrWidth (32),
        .AxiDataWidth (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .slv_aw_addr_i  (aw_addr),
        .slv_aw_valid_i (aw_valid),
        .slv_aw_ready_o (aw_ready),
        .slv_w_data_i   (w_data),
        .slv_w_strb_i   (w_strb),
        .slv_w_valid_i  (w_valid),
        .slv_w_ready_o  (w_ready),
        .slv_b_resp_o   (b_resp),
        .slv_b_valid_o  (b_valid),
        .slv_b_ready_i  (b_ready),
        .slv_ar_addr_i  (ar_addr),
        .slv_ar_valid_i (ar_valid),
        .slv_ar_ready_o (ar_ready),
        .slv_r_data_o   (r_data),
        .slv_r_resp_o   (r_resp),
        .slv_r_valid_o  (r_valid),
        .slv_r_ready_i  (r_ready),
        .base_addr_i    (Base),
        .event_i        (ev),
        .irq_o          (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state: register map and outstanding responses as seen after the last edge.
    bit          m_en;
    bit [NC-1:0] m_ovf, m_ien, m_cen;
    logic [31:0] m_cnt [NC];
    bit          m_irq;
    bit          m_b_pend, m_r_pend;
    logic [1:0]  m_b_resp, m_r_resp;
    logic [31:0] m_r_data;
    bit          last_wr_acc, last_rd_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake timed out", name);
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output bit err);
        logic [31:0] word;
        word = (addr - Base) >> 2;
        d    = 32'h0;
        err  = 1'b0;
        if (word == 0)                         d = {31'b0, m_en};
        else if (word == 1)                    d = 32'(m_ovf);
        else if (word == 2)                    d = 32'(m_ien);
        else if (word == 3)                    d = 32'(m_cen);
        else if (word >= 64 && word < 64 + NC) d = m_cnt[int'(word) - 64];
        else                                   err = 1'b1;
    endtask

    // Advance one clock: derive the next model state from the current inputs, then commit.
    task automatic step();
        logic [31:0] n_cnt [NC];
        bit          n_en, n_irq, n_bp, n_rp, wr_acc, rd_acc, clr, werr, rerr;
        bit [NC-1:0] n_ovf, n_ien, n_cen;
        logic [1:0]  n_bresp, n_rresp;
        logic [31:0] n_rdata, word;
        int          widx;
        wr_acc  = !rst && aw_valid && w_valid && !m_b_pend;
        rd_acc  = !rst && ar_valid && !m_r_pend;
        n_en    = m_en;
        n_ovf   = m_ovf;
        n_ien   = m_ien;
        n_cen   = m_cen;
        for (int i = 0; i < NC; i++) n_cnt[i] = m_cnt[i];
        clr     = 1'b0;
        werr    = 1'b0;
        widx    = -1;
        n_bp    = m_b_pend;
        n_bresp = m_b_resp;
        n_rp    = m_r_pend;
        n_rresp = m_r_resp;
        n_rdata = m_r_data;
        if (rd_acc) begin
            model_read(ar_addr, n_rdata, rerr);
            n_rresp = rerr ? SlvErr : Okay;
            n_rp    = 1'b1;
        end else if (r_ready) begin
            n_rp = 1'b0;
        end
        if (wr_acc) begin
            word = (aw_addr - Base) >> 2;
            if (word == 0) begin
                if (w_strb[0]) begin
                    n_en = w_data[0];
                    clr  = w_data[1];
                end
            end else if (word == 1) begin
                for (int i = 0; i < NC; i++) if (w_strb[i/8] && w_data[i]) n_ovf[i] = 1'b0;
            end else if (word == 2) begin
                for (int i = 0; i < NC; i++) if (w_strb[i/8]) n_ien[i] = w_data[i];
            end else if (word == 3) begin
                for (int i = 0; i < NC; i++) if (w_strb[i/8]) n_cen[i] = w_data[i];
            end else if (word >= 64 && word < 64 + NC) begin
                widx = int'(word) - 64;
            end else begin
                werr = 1'b1;
            end
            n_bp    = 1'b1;
            n_bresp = werr ? SlvErr : Okay;
        end else if (b_ready) begin
            n_bp = 1'b0;
        end
        for (int i = 0; i < NC; i++) begin
            if (clr) begin
                n_cnt[i] = 32'h0;
            end else if (i == widx) begin
                for (int b = 0; b < 4; b++) if (w_strb[b]) n_cnt[i][8*b +: 8] = w_data[8*b +: 8];
            end else if (m_en && m_cen[i] && ev[i]) begin
                if (m_cnt[i] == 32'hFFFF_FFFF) begin
                    n_cnt[i] = 32'h0;
                    n_ovf[i] = 1'b1;
                end else begin
                    n_cnt[i] = m_cnt[i] + 32'd1;
                end
            end
        end
        if (clr) n_ovf = '0;
        n_irq = |(m_ovf & m_ien);
        @(posedge clk);
        #1;
        if (rst) begin
            m_en = 1'b0; m_ovf = '0; m_ien = '0; m_cen = '0; m_irq = 1'b0;
            for (int i = 0; i < NC; i++) m_cnt[i] = 32'h0;
            m_b_pend = 1'b0; m_b_resp = Okay;
            m_r_pend = 1'b0; m_r_resp = Okay; m_r_data = 32'h0;
        end else begin
            m_en = n_en; m_ovf = n_ovf; m_ien = n_ien; m_cen = n_cen; m_irq = n_irq;
            for (int i = 0; i < NC; i++) m_cnt[i] = n_cnt[i];
            m_b_pend = n_bp; m_b_resp = n_bresp;
            m_r_pend = n_rp; m_r_resp = n_rresp; m_r_data = n_rdata;
        end
        last_wr_acc = wr_acc;
        last_rd_acc = rd_acc;
    endtask

    task automatic wr(input string name, input logic [31:0] off, input logic [31:0] data,
                      input logic [3:0] strb, input logic [NC-1:0] evv,
                      input logic [1:0] exp_resp);
        int k;
        aw_addr  = Base + off;
        w_data   = data;
        w_strb   = strb;
        aw_valid = 1'b1;
        w_valid  = 1'b1;
        ev       = evv;
        k = 0;
        do begin
            step();
            k++;
            ev = '0;
        end while (!last_wr_acc && k < 20);
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        if (!last_wr_acc) begin
            timeout(name);
            return;
        end
        chk({name, "_bvalid"}, 32'(b_valid), 32'd1);
        chk({name, "_bresp"}, 32'(b_resp), 32'(exp_resp));
        k = 0;
        while (m_b_pend && k < 20) begin
            step();
            k++;
        end
        if (m_b_pend) timeout({name, "_b"});
    endtask

    task automatic rd(input string name, input logic [31:0] off, input logic [31:0] exp_data,
                      input logic [1:0] exp_resp);
        int k;
        ar_addr  = Base + off;
        ar_valid = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!last_rd_acc && k < 20);
        ar_valid = 1'b0;
        if (!last_rd_acc) begin
            timeout(name);
            return;
        end
        chk({name, "_rvalid"}, 32'(r_valid), 32'd1);
        chk({name, "_data"}, r_data, exp_data);
        chk({name, "_resp"}, 32'(r_resp), 32'(exp_resp));
        step();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_irq", 32'(irq), 32'(m_irq));
            chk("cyc_bvalid", 32'(b_valid), 32'(m_b_pend));
            if (m_b_pend) chk("cyc_bresp", 32'(b_resp), 32'(m_b_resp));
            chk("cyc_rvalid", 32'(r_valid), 32'(m_r_pend));
            if (m_r_pend) begin
                chk("cyc_rdata", r_data, m_r_data);
                chk("cyc_rresp", 32'(r_resp), 32'(m_r_resp));
            end
            chk("cyc_awready", 32'(aw_ready), 32'(!rst && aw_valid && w_valid && !m_b_pend));
            chk("cyc_wready", 32'(w_ready), 32'(!rst && aw_valid && w_valid && !m_b_pend));
            chk("cyc_arready", 32'(ar_ready), 32'(!rst && !m_r_pend));
        end
    end

    initial begin
        rst      = 1'b1;
        aw_addr  = Base;
        aw_valid = 1'b0;
        w_data   = 32'h0;
        w_strb   = 4'h0;
        w_valid  = 1'b0;
        b_ready  = 1'b1;
        ar_addr  = Base;
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        ev       = '0;
        step();
        step();
        chk_en = 1'b1;
        rst    = 1'b0;
        step();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_bvalid", 32'(b_valid), 32'd0);
        chk("rst_rvalid", 32'(r_valid), 32'd0);
        rd("rst_ctrl", 32'h000, 32'h0, Okay);
        rd("rst_ovf", 32'h004, 32'h0, Okay);
        rd("rst_irqen", 32'h008, 32'h0, Okay);
        rd("rst_cnten", 32'h00C, 32'h0, Okay);
        rd("rst_cnt0", 32'h100, 32'h0, Okay);

        // Ten events on counter 0 only.
        wr("en_ctrl", 32'h000, 32'h1, 4'hF, '0, Okay);
        wr("en_cnt0", 32'h00C, 32'h1, 4'hF, '0, Okay);
        ev = 8'h01;
        repeat (10) step();
        ev = '0;
        rd("cnt0_ten", 32'h100, 32'd10, Okay);
        rd("cnt1_zero", 32'h104, 32'd0, Okay);

        // Wrap and overflow interrupt.
        wr("cnt0_preset", 32'h100, 32'hFFFF_FFFE, 4'hF, '0, Okay);
        wr("irqen0", 32'h008, 32'h1, 4'hF, '0, Okay);
        ev = 8'h01;
        repeat (2) step();
        ev = '0;
        rd("cnt0_wrap", 32'h100, 32'h0, Okay);
        rd("ovf_set", 32'h004, 32'h1, Okay);
        chk("irq_high", 32'(irq), 32'd1);
        wr("ovf_w1c", 32'h004, 32'h1, 4'hF, '0, Okay);
        chk("irq_low", 32'(irq), 32'd0);

        // Byte-strobed counter write drops the same-cycle event.
        wr("cnt2_init", 32'h108, 32'h1234_5678, 4'hF, '0, Okay);
        wr("cnten_05", 32'h00C, 32'h5, 4'hF, '0, Okay);
        wr("cnt2_byte", 32'h108, 32'h0000_00AB, 4'b0001, 8'h04, Okay);
        rd("cnt2_merged", 32'h108, 32'h1234_56AB, Okay);

        // Overflow set wins over a simultaneous W1C.
        wr("cnt1_max", 32'h104, 32'hFFFF_FFFF, 4'hF, '0, Okay);
        wr("cnten_07", 32'h00C, 32'h7, 4'hF, '0, Okay);
        wr("ovf_race", 32'h004, 32'h2, 4'hF, 8'h02, Okay);
        rd("ovf_race_kept", 32'h004, 32'h2, Okay);
        rd("cnt1_wrapped", 32'h104, 32'h0, Okay);

        // Decode errors.
        rd("bad_rd_010", 32'h010, 32'h0, SlvErr);
        wr("bad_wr_120", 32'h120, 32'hDEAD_BEEF, 4'hF, '0, SlvErr);
        rd("cnt7_zero", 32'h11C, 32'h0, Okay);
        rd("cnt2_intact", 32'h108, 32'h1234_56AB, Okay);
        rd("below_base", 32'hFFFF_FFFC, 32'h0, SlvErr);

        // Clear-all keeps the enable bit and reads back as 0.
        wr("clear_all", 32'h000, 32'h3, 4'hF, '0, Okay);
        rd("ctrl_after_clr", 32'h000, 32'h1, Okay);
        rd("cnt2_after_clr", 32'h108, 32'h0, Okay);
        rd("ovf_after_clr", 32'h004, 32'h0, Okay);

        // Second write is held off while B is stalled.
        b_ready  = 1'b0;
        aw_addr  = Base + 32'h008;
        w_data   = 32'hFF;
        w_strb   = 4'hF;
        aw_valid = 1'b1;
        w_valid  = 1'b1;
        step();
        chk("stall_bvalid0", 32'(b_valid), 32'd1);
        w_data = 32'h03;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_awready", 32'(aw_ready), 32'd0);
            chk("stall_bvalid", 32'(b_valid), 32'd1);
        end
        b_ready = 1'b1;
        step();
        chk("stall_bdone", 32'(b_valid), 32'd0);
        chk("second_awready", 32'(aw_ready), 32'd1);
        step();
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        chk("second_bvalid", 32'(b_valid), 32'd1);
        step();
        rd("irqen_second", 32'h008, 32'h3, Okay);

        // Reset while a B response is outstanding.
        b_ready  = 1'b0;
        aw_addr  = Base + 32'h00C;
        w_data   = 32'hF0;
        aw_valid = 1'b1;
        w_valid  = 1'b1;
        step();
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        step();
        step();
        chk("pre_rst_bvalid", 32'(b_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_bvalid_drop", 32'(b_valid), 32'd0);
        rst     = 1'b0;
        b_ready = 1'b1;
        step();
        rd("rst2_ctrl", 32'h000, 32'h0, Okay);
        rd("rst2_irqen", 32'h008, 32'h0, Okay);
        rd("rst2_cnten", 32'h00C, 32'h0, Okay);
        rd("rst2_cnt0", 32'h100, 32'h0, Okay);
        chk("rst2_irq", 32'(irq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
